// File: rtl/clint_timer.sv
// clint_timer
//   Core-local timer (CLINT subset). Holds the 64-bit mtime counter and the
//   mtimecmp compare register, both reachable through a single-outstanding
//   valid/ready request/response port. timer_intr is the registered level
//   (mtime >= mtimecmp, unsigned) consumed by the CSR trap logic.
//
// Ports
//   clk         in   1   core clock
//   rst         in   1   synchronous reset, active-high
//   req_valid   in   1   request valid
//   req_ready   out  1   block can accept a request (IDLE only)
//   req_we      in   1   1 = write, 0 = read
//   req_addr    in   64  byte address inside [BASE_ADDR, BASE_ADDR+64K)
//   req_wdata   in   64  write data
//   req_wmask   in   8   byte enables for writes
//   resp_valid  out  1   response valid (RESP state)
//   resp_ready  in   1   response consumed
//   resp_rdata  out  64  read data (0 for writes and errors)
//   resp_err    out  1   unmapped or misaligned offset
//   mtime_stop  in   1   freeze mtime and the prescaler
//   timer_intr  out  1   timer interrupt level
module clint_timer #(
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0200_0000,
  parameter logic [15:0] MTIMECMP_OFF = 16'h4000,
  parameter logic [15:0] MTIME_OFF    = 16'hBFF8,
  parameter int unsigned TICK_DIV     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        mtime_stop,
  output logic        timer_intr
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] mtime_reg;
  logic [63:0] mtimecmp_reg;
  logic [PW-1:0] presc_reg;
  logic        intr_reg;
  logic [63:0] rdata_reg;
  logic        err_reg;

  logic        accept;
  logic        tick;
  logic [63:0] offset;
  logic        in_window;
  logic        aligned;
  logic        hit_time;
  logic        hit_cmp;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_merged;
  logic [63:0] cmp_merged;

  // Addresses below BASE_ADDR wrap to a huge offset, so a single upper-bits
  // test covers both ends of the 64K window.
  assign offset    = req_addr - BASE_ADDR;
  assign in_window = (offset[63:16] == 48'd0);
  assign aligned   = (req_addr[2:0] == 3'b000);
  assign hit_time  = in_window && aligned && (offset[15:0] == MTIME_OFF);
  assign hit_cmp   = in_window && aligned && (offset[15:0] == MTIMECMP_OFF);

  assign tick      = !mtime_stop && (presc_reg == PRESC_MAX);
  assign mtime_inc = tick ? (mtime_reg + 64'd1) : mtime_reg;

  // Byte merge. For mtime the unwritten bytes come from the already
  // incremented value, so a write colliding with a tick keeps the tick in
  // the bytes software did not touch.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_merge
      assign mtime_merged[gi*8 +: 8] = req_wmask[gi] ? req_wdata[gi*8 +: 8]
                                                     : mtime_inc[gi*8 +: 8];
      assign cmp_merged[gi*8 +: 8]   = req_wmask[gi] ? req_wdata[gi*8 +: 8]
                                                     : mtimecmp_reg[gi*8 +: 8];
    end
  endgenerate

  // Handshake FSM: one request in flight; no accept on the consume cycle.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mtime_reg    <= 64'd0;
      mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_reg    <= '0;
      intr_reg     <= 1'b0;
      rdata_reg    <= 64'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Compare uses the pre-edge register values, so intr lags by a cycle.
      intr_reg  <= (mtime_reg >= mtimecmp_reg);

      if (!mtime_stop) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
      end

      if (accept && req_we && hit_time) begin
        mtime_reg <= mtime_merged;
      end else begin
        mtime_reg <= mtime_inc;
      end

      if (accept && req_we && hit_cmp) begin
        mtimecmp_reg <= cmp_merged;
      end

      // Read data is captured at acceptance and then held while in RESP.
      if (accept) begin
        err_reg <= !(hit_time || hit_cmp);
        if (!req_we && hit_time) begin
          rdata_reg <= mtime_reg;
        end else if (!req_we && hit_cmp) begin
          rdata_reg <= mtimecmp_reg;
        end else begin
          rdata_reg <= 64'd0;
        end
      end
    end
  end

  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign timer_intr = intr_reg;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer
//   Directed bench for clint_timer. Two instances share all inputs: u_div1
//   (TICK_DIV=1) is the main target, u_div4 (TICK_DIV=4) covers prescaler
//   freezing. Expected responses are queued when a request is issued and
//   popped when the response is observed.
module tb_clint_timer;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_wmask = 8'd0;
  logic        resp_ready = 1'b0;
  logic        mtime_stop = 1'b0;

  logic        req_ready_a, resp_valid_a, resp_err_a, timer_intr_a;
  logic [63:0] resp_rdata_a;
  logic        req_ready_b, resp_valid_b, resp_err_b, timer_intr_b;
  logic [63:0] resp_rdata_b;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .mtime_stop(mtime_stop), .timer_intr(timer_intr_a)
  );

  clint_timer #(.TICK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .mtime_stop(mtime_stop), .timer_intr(timer_intr_b)
  );

  // Edge counter and count of non-stopped edges since the last reset.
  int unsigned edge_cnt = 0;
  int unsigned act = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge clk) begin
    if (rst) act <= 0;
    else if (!mtime_stop) act <= act + 1;
  end

  // Anchor for the TICK_DIV=1 mtime: value right after edge medge is mbase.
  logic [63:0] mbase = 64'd0;
  int unsigned medge = 0;

  // mtime seen by the next edge, valid when called just after an edge.
  function automatic logic [63:0] mtime_now();
    return mbase + 64'(edge_cnt - medge);
  endfunction

  typedef struct {
    logic [63:0] rd;
    logic        err;
    logic [63:0] rd_b;
    bit          chk_b;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic exp_t mk(logic [63:0] rd, logic err, logic [63:0] rd_b,
                              bit chk_b, string tag);
    exp_t e;
    e.rd = rd; e.err = err; e.rd_b = rd_b; e.chk_b = chk_b; e.tag = tag;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one request; returns just after the acceptance edge.
  task automatic issue(logic we, logic [63:0] addr, logic [63:0] wd,
                       logic [7:0] mask, exp_t e);
    sb.push_back(e);
    req_we = we; req_addr = addr; req_wdata = wd; req_wmask = mask;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wmask = 8'd0;
  endtask

  // Wait (bounded) for the response, compare against the queue, consume it.
  task automatic finish_xact();
    exp_t e;
    int n = 0;
    while (resp_valid_a !== 1'b1 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk1({e.tag, "_valid"}, resp_valid_a, 1'b1);
    chk({e.tag, "_rdata"}, resp_rdata_a, e.rd);
    chk1({e.tag, "_err"}, resp_err_a, e.err);
    if (e.chk_b) chk({e.tag, "_rdata_b"}, resp_rdata_b, e.rd_b);
    $display("[TB] %s: rdata=%h err=%b", e.tag, resp_rdata_a, resp_err_a);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk1({e.tag, "_done"}, resp_valid_a, 1'b0);
  endtask

  task automatic xact(logic we, logic [63:0] addr, logic [63:0] wd,
                      logic [7:0] mask, exp_t e);
    issue(we, addr, wd, mask, e);
    finish_xact();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold_val;
    logic [63:0] inc_val;
    logic [63:0] frozen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mbase = 64'd0; medge = edge_cnt;
    chk1("rst_req_ready", req_ready_a, 1'b1);
    chk1("rst_resp_valid", resp_valid_a, 1'b0);
    chk("rst_rdata", resp_rdata_a, 64'd0);
    chk1("rst_err", resp_err_a, 1'b0);
    chk1("rst_intr", timer_intr_a, 1'b0);
    chk1("rst_resp_valid_b", resp_valid_b, 1'b0);

    // 1: idle 10 cycles, then read mtime
    repeat (10) begin
      @(posedge clk); #1;
      chk1("t1_intr", timer_intr_a, 1'b0);
    end
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(mtime_now(), 1'b0, 64'd0, 0, "t1_rd_mtime"));

    // 2: mtimecmp = 20, watch the rise, then rewrite all-ones
    xact(1'b1, A_CMP, 64'd20, 8'hFF, mk(64'd0, 1'b0, 64'd0, 0, "t2_wr_cmp20"));
    repeat (12) begin
      @(posedge clk); #1;
      chk1("t2_intr_rise", timer_intr_a, (mtime_now() - 64'd1) >= 64'd20);
    end
    issue(1'b1, A_CMP, ONES, 8'hFF, mk(64'd0, 1'b0, 64'd0, 0, "t2_wr_cmp_ones"));
    chk1("t2_intr_lag", timer_intr_a, 1'b1);
    finish_xact();
    chk1("t2_intr_fall", timer_intr_a, 1'b0);

    // 3: mtime wrap with a one-cycle interrupt pulse
    issue(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF,
          mk(64'd0, 1'b0, 64'd0, 0, "t3_wr_mtime"));
    mbase = 64'hFFFF_FFFF_FFFF_FFFE; medge = edge_cnt;
    chk1("t3_intr_a", timer_intr_a, 1'b0);
    finish_xact();
    chk1("t3_intr_fffe", timer_intr_a, 1'b0);
    @(posedge clk); #1;
    chk1("t3_intr_ffff", timer_intr_a, 1'b1);
    @(posedge clk); #1;
    chk1("t3_intr_wrap", timer_intr_a, 1'b0);
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(mtime_now(), 1'b0, 64'd0, 0, "t3_rd_wrap"));

    // 4: response back-pressure; a competing request must not be taken
    hold_val = mtime_now();
    issue(1'b0, A_TIME, 64'd0, 8'h00, mk(hold_val, 1'b0, 64'd0, 0, "t4_rd_hold"));
    req_valid = 1'b1; req_we = 1'b1; req_addr = A_CMP;
    req_wdata = 64'd0; req_wmask = 8'hFF;
    repeat (5) begin
      chk1("t4_hold_valid", resp_valid_a, 1'b1);
      chk("t4_hold_rdata", resp_rdata_a, hold_val);
      chk1("t4_hold_ready", req_ready_a, 1'b0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_we = 1'b0; req_wmask = 8'd0;
    finish_xact();
    xact(1'b0, A_CMP, 64'd0, 8'h00, mk(ONES, 1'b0, 64'd0, 0, "t4_rd_cmp"));

    // 5: decode errors, no-op write, masked write colliding with a tick
    xact(1'b0, BASE + 64'h8, 64'd0, 8'h00, mk(64'd0, 1'b1, 64'd0, 0, "t5_rd_off8"));
    xact(1'b0, A_TIME + 64'h4, 64'd0, 8'h00, mk(64'd0, 1'b1, 64'd0, 0, "t5_rd_misal"));
    xact(1'b1, BASE + 64'h8, 64'd0, 8'hFF, mk(64'd0, 1'b1, 64'd0, 0, "t5_wr_off8"));
    xact(1'b0, BASE + 64'h1_4000, 64'd0, 8'h00, mk(64'd0, 1'b1, 64'd0, 0, "t5_rd_outwin"));
    xact(1'b1, A_CMP, 64'd0, 8'h00, mk(64'd0, 1'b0, 64'd0, 0, "t5_wr_mask0"));
    xact(1'b0, A_CMP, 64'd0, 8'h00, mk(ONES, 1'b0, 64'd0, 0, "t5_rd_cmp"));
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(mtime_now(), 1'b0, 64'd0, 0, "t5_rd_mtime"));
    issue(1'b1, A_TIME, 64'h0000_0000_FFFF_FFFE, 8'hFF,
          mk(64'd0, 1'b0, 64'd0, 0, "t5_wr_mtime"));
    mbase = 64'h0000_0000_FFFF_FFFE; medge = edge_cnt;
    finish_xact();
    inc_val = mtime_now() + 64'd1;
    issue(1'b1, A_TIME, 64'h1111_2222_3333_4444, 8'h0F,
          mk(64'd0, 1'b0, 64'd0, 0, "t5_wr_masked"));
    mbase = {inc_val[63:32], 32'h3333_4444}; medge = edge_cnt;
    finish_xact();
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(mtime_now(), 1'b0, 64'd0, 0, "t5_rd_merged"));

    // 6: reset during RESP, write during reset, then freeze with TICK_DIV=4
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_TIME;
    @(posedge clk); #1;
    chk1("t6_in_resp", resp_valid_a, 1'b1);
    rst = 1'b1;
    req_we = 1'b1; req_addr = A_CMP; req_wdata = 64'd0; req_wmask = 8'hFF;
    @(posedge clk); #1;
    chk1("t6_rst_valid", resp_valid_a, 1'b0);
    chk1("t6_rst_valid_b", resp_valid_b, 1'b0);
    @(posedge clk); #1;
    chk1("t6_rst_noacc", resp_valid_a, 1'b0);
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_wmask = 8'd0;
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(64'(act), 1'b0, 64'(act / 4), 1, "t6_rd_mtime0"));
    xact(1'b0, A_CMP, 64'd0, 8'h00, mk(ONES, 1'b0, ONES, 1, "t6_rd_cmp"));
    mtime_stop = 1'b1;
    frozen = 64'(act);
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(frozen, 1'b0, frozen / 4, 1, "t6_stop_rd1"));
    xact(1'b0, A_TIME, 64'd0, 8'h00, mk(frozen, 1'b0, frozen / 4, 1, "t6_stop_rd2"));
    repeat (4) @(posedge clk);
    #1;
    mtime_stop = 1'b0;
    @(posedge clk); #1;
    mtime_stop = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mtime_stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (4) begin
      xact(1'b0, A_TIME, 64'd0, 8'h00, mk(64'(act), 1'b0, 64'(act / 4), 1, "t6_run_rd"));
    end
    chk1("t6_intr", timer_intr_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
